line_fetch: RTL and testbench

Framebuffer line prefetcher and pixel output stage for the 480x272 LCD path. It sits directly downstream of the display timing generator and consumes its `pixel_clk`, `DrawX`, `DrawY`, `hs`, `vs` and `blank` outputs. While line N is on screen, it fetches line N+1 from framebuffer memory into a ping-pong line buffer. It then presents RGB565 pixels, with the sync and blank signals delayed to stay aligned.

---
 rtl/line_fetch.sv | 213 +++++++++++++++++++++
 tb/tb_line_fetch.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/line_fetch.sv
`default_nettype none
// ============================================================================
// Module   : line_fetch
// Purpose  : Ping-pong line prefetcher and RGB565 output stage for 480x272 LCD
// Revision : 1.0 - initial release
// ============================================================================
module line_fetch #(
    parameter int H_ACTIVE = 480,
    parameter int V_ACTIVE = 272,
    parameter int V_LAST   = 350
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        pixel_clk,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic        blank_in,
    output logic        mem_req,
    output logic [16:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] rgb,
    output logic        hs_out,
    output logic        vs_out,
    output logic        blank_out,
    output logic        underrun
);

    localparam int              c_XW       = $clog2(H_ACTIVE);
    localparam logic [9:0]      c_H_ACTIVE = 10'(H_ACTIVE);
    localparam logic [9:0]      c_V_ACTIVE = 10'(V_ACTIVE);
    localparam logic [9:0]      c_V_LAST   = 10'(V_LAST);
    localparam logic [c_XW-1:0] c_X_LAST   = c_XW'(H_ACTIVE - 1);
    localparam logic [c_XW-1:0] c_X_ONE    = c_XW'(1);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_REQ  = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic            r_pclk_d;
    logic            r_pstb_d;
    logic            w_pstb;
    logic            w_line_start;
    logic [9:0]      w_target;
    logic            w_fetch;
    logic            w_in_req;
    logic            w_done;
    logic            w_ack_write;
    logic            w_last_ack;
    logic            w_swap;
    logic            w_rd_next;

    logic            r_rd_bank;
    logic            r_wr_bank;
    logic [1:0]      r_valid;
    logic            r_line_ok;
    logic [c_XW-1:0] r_fx;
    logic [16:0]     r_base;
    logic            r_underrun;

    logic [9:0]      r_x1;
    logic            r_hs1;
    logic            r_vs1;
    logic            r_blank1;
    logic [c_XW-1:0] w_rd_idx;
    logic            w_show;
    logic [15:0]     w_pix;

    logic [15:0]     r_rgb;
    logic            r_hs2;
    logic            r_vs2;
    logic            r_blank2;

    logic [15:0]     r_buf [2][H_ACTIVE];

    assign w_pstb       = r_pclk_d & ~pixel_clk;
    assign w_line_start = w_pstb & (DrawX == 10'd0);
    assign w_target     = (DrawY == c_V_LAST) ? 10'd0 : DrawY + 10'd1;
    assign w_fetch      = w_line_start & (w_target < c_V_ACTIVE);
    assign w_in_req     = (r_state == c_S_REQ);
    assign w_done       = (r_state == c_S_DONE);
    assign w_ack_write  = w_in_req & mem_ack;
    assign w_last_ack   = w_ack_write & (r_fx == c_X_LAST);
    // A fetch finishing in the very cycle of a line start still counts as complete.
    assign w_swap       = r_line_ok | w_done;
    assign w_rd_next    = r_rd_bank ^ w_swap;

    assign mem_addr  = r_base + 17'(r_fx);
    assign rgb       = r_rgb;
    assign hs_out    = r_hs2;
    assign vs_out    = r_vs2;
    assign blank_out = r_blank2;
    assign underrun  = r_underrun;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        mem_req      = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                w_state_next = c_S_IDLE;
            end
            c_S_REQ: begin
                mem_req = 1'b1;
                if (w_last_ack) begin
                    w_state_next = c_S_DONE;
                end
            end
            c_S_DONE: begin
                w_state_next = c_S_IDLE;
            end
            default: begin
                w_state_next = c_S_IDLE;
            end
        endcase
        // A line start aborts any fetch in flight and rearms for the new target.
        if (w_line_start) begin
            w_state_next = w_fetch ? c_S_REQ : c_S_IDLE;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rd_bank  <= 1'b0;
            r_wr_bank  <= 1'b1;
            r_valid    <= 2'b00;
            r_line_ok  <= 1'b0;
            r_fx       <= '0;
            r_base     <= '0;
            r_underrun <= 1'b0;
        end else begin
            if (w_ack_write) begin
                r_fx <= r_fx + c_X_ONE;
            end
            if (w_done) begin
                r_line_ok          <= 1'b1;
                r_valid[r_wr_bank] <= 1'b1;
            end
            if (w_line_start) begin
                r_rd_bank <= w_rd_next;
                r_line_ok <= 1'b0;
                // The line now starting would have read the aborted bank: blank it.
                if (w_in_req) begin
                    r_underrun         <= 1'b1;
                    r_valid[r_rd_bank] <= 1'b0;
                end
                if (w_fetch) begin
                    r_wr_bank           <= ~w_rd_next;
                    r_valid[~w_rd_next] <= 1'b0;
                    r_fx                <= '0;
                    r_base              <= 17'(w_target) * 17'(H_ACTIVE);
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (w_ack_write) begin
            r_buf[r_wr_bank][r_fx] <= mem_rdata;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pclk_d <= 1'b0;
            r_pstb_d <= 1'b0;
            r_x1     <= '0;
            r_hs1    <= 1'b1;
            r_vs1    <= 1'b1;
            r_blank1 <= 1'b0;
        end else begin
            r_pclk_d <= pixel_clk;
            r_pstb_d <= w_pstb;
            if (w_pstb) begin
                r_x1     <= DrawX;
                r_hs1    <= hs_in;
                r_vs1    <= vs_in;
                r_blank1 <= blank_in;
            end
        end
    end

    assign w_rd_idx = (r_x1 < c_H_ACTIVE) ? r_x1[c_XW-1:0] : '0;
    assign w_show   = r_blank1 & (r_x1 < c_H_ACTIVE) & r_valid[r_rd_bank];
    assign w_pix    = r_buf[r_rd_bank][w_rd_idx];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rgb    <= '0;
            r_hs2    <= 1'b1;
            r_vs2    <= 1'b1;
            r_blank2 <= 1'b0;
        end else if (r_pstb_d) begin
            r_rgb    <= w_show ? w_pix : 16'h0000;
            r_hs2    <= r_hs1;
            r_vs2    <= r_vs1;
            r_blank2 <= r_blank1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_line_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_fetch
// Purpose  : Directed line-by-line bench for line_fetch with a latency memory
// Revision : 1.0 - initial release
// ============================================================================
module tb_line_fetch;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        pixel_clk;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        hs_in;
    logic        vs_in;
    logic        blank_in;
    logic        mem_req;
    logic [16:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] rgb;
    logic        hs_out;
    logic        vs_out;
    logic        blank_out;
    logic        underrun;

    line_fetch dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .pixel_clk (pixel_clk),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .hs_in     (hs_in),
        .vs_in     (vs_in),
        .blank_in  (blank_in),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .rgb       (rgb),
        .hs_out    (hs_out),
        .vs_out    (vs_out),
        .blank_out (blank_out),
        .underrun  (underrun)
    );

    always #10 Clk = ~Clk;

    typedef struct {
        int y;
        int hsx;
        int disp;
        int exp_nack;
        int exp_first;
        int exp_last;
        int exp_unr;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    int          lat = 2;
    int          cnt = 0;
    logic [16:0] seen_addr = 17'h1FFFF;
    int          nack, first_addr, last_addr, seq_err, req_cycles;

    int          pix_err, bad_x, bad_ph;
    logic [18:0] bad_got, bad_exp;
    logic [15:0] p_rgb;
    logic        p_hs, p_vs, p_bl;
    logic        hs_n4, hs_n5;
    logic [15:0] hs_rgb;
    logic [16:0] addr0;
    logic        req0;

    // Memory model: data = addr[15:0], ack 'lat' cycles after an address appears.
    always @(negedge Clk) begin
        if (mem_req) req_cycles++;
        if (mem_ack) begin
            mem_ack = 1'b0;
            cnt = 0;
        end else if (mem_req) begin
            if (mem_addr != seen_addr) cnt = 0;
            seen_addr = mem_addr;
            cnt++;
            if (cnt >= lat) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_addr[15:0];
                if (nack > 0 && int'(mem_addr) != last_addr + 1) seq_err++;
                if (nack == 0) first_addr = int'(mem_addr);
                last_addr = int'(mem_addr);
                nack++;
            end
        end else begin
            cnt = 0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic note_bad(input int x, input int ph, input logic [18:0] got, input logic [18:0] exp);
        pix_err++;
        if (pix_err == 1) begin
            bad_x = x; bad_ph = ph; bad_got = got; bad_exp = exp;
        end
    endtask

    task automatic set_prev_reset();
        p_rgb = 16'h0000; p_hs = 1'b1; p_vs = 1'b1; p_bl = 1'b0;
    endtask

    // One line of the timing generator: each pixel is 3 Clk high + 3 Clk low of pixel_clk.
    task automatic run_line(input int y, input int hsx, input int disp, input int npix);
        logic [31:0] pat;
        logic [15:0] erg;
        logic        eh, ev, eb;
        nack = 0; seq_err = 0; req_cycles = 0; first_addr = -1; last_addr = -1;
        pix_err = 0; hs_n4 = 1'bx; hs_n5 = 1'bx; hs_rgb = 16'hxxxx;
        for (int x = 0; x < npix; x++) begin
            @(negedge Clk);
            eb = (x < 480) && (y < 272);
            eh = (x == hsx) ? 1'b0 : 1'b1;
            ev = (y == 349) ? 1'b0 : 1'b1;
            DrawX = 10'(x); DrawY = 10'(y);
            hs_in = eh; vs_in = ev; blank_in = eb;
            pixel_clk = 1'b1;
            repeat (3) @(negedge Clk);
            pixel_clk = 1'b0;
            @(negedge Clk);
            if ({rgb, hs_out, vs_out, blank_out} !== {p_rgb, p_hs, p_vs, p_bl})
                note_bad(x, 4, {rgb, hs_out, vs_out, blank_out}, {p_rgb, p_hs, p_vs, p_bl});
            if (x == hsx) hs_n4 = hs_out;
            @(negedge Clk);
            pat = 32'(disp * 480 + x);
            erg = (disp >= 0 && eb) ? pat[15:0] : 16'h0000;
            if ({rgb, hs_out, vs_out, blank_out} !== {erg, eh, ev, eb})
                note_bad(x, 5, {rgb, hs_out, vs_out, blank_out}, {erg, eh, ev, eb});
            if (x == hsx) begin
                hs_n5 = hs_out;
                hs_rgb = rgb;
            end
            if (x == 0) begin
                addr0 = mem_addr;
                req0 = mem_req;
            end
            p_rgb = erg; p_hs = eh; p_vs = ev; p_bl = eb;
        end
    endtask

    task automatic apply_row(input vec_t v);
        logic [31:0] pat;
        run_line(v.y, v.hsx, v.disp, 525);
        check($sformatf("pix_y%0d", v.y), pix_err, 0);
        if (pix_err != 0)
            $display("  first bad sample y=%0d x=%0d phase=%0d got=%h want=%h (rgb,hs,vs,blank)",
                     v.y, bad_x, bad_ph, bad_got, bad_exp);
        check($sformatf("underrun_y%0d", v.y), int'(underrun), v.exp_unr);
        if (v.exp_nack >= 0) begin
            check($sformatf("nack_y%0d", v.y), nack, v.exp_nack);
            if (v.exp_nack > 0) begin
                check($sformatf("first_addr_y%0d", v.y), first_addr, v.exp_first);
                check($sformatf("last_addr_y%0d", v.y), last_addr, v.exp_last);
                check($sformatf("addr_seq_y%0d", v.y), seq_err, 0);
            end else begin
                check($sformatf("req_cycles_y%0d", v.y), req_cycles, 0);
            end
        end
        if (v.hsx >= 0) begin
            pat = 32'(v.disp * 480 + v.hsx);
            check("hs_align", int'({hs_n4, hs_n5}), 2);
            check("hs_rgb", int'(hs_rgb), int'(pat[15:0]));
        end
    endtask

    vec_t tbl [9];

    initial begin
        // {y, hs pulse x, displayed line (-1 = black), acks, first addr, last addr, underrun}
        tbl[0] = '{350, -1, -1, 480, 0,      479,    0};
        tbl[1] = '{0,  100,  0, 480, 480,    959,    0};
        tbl[2] = '{1,   -1,  1, 480, 960,    1439,   0};
        tbl[3] = '{270, -1,  2, 480, 130080, 130559, 0}; // shows line 2, prefetched during y=1
        tbl[4] = '{271, -1, 271, 0,  0,      0,      0};
        tbl[5] = '{272, -1, -1,  0,  0,      0,      0};
        tbl[6] = '{349, -1, -1,  0,  0,      0,      0};
        tbl[7] = '{350, -1, -1, 480, 0,      479,    0};
        tbl[8] = '{0,   -1,  0, 480, 480,    959,    0};

        Reset_n = 1'b0; pixel_clk = 1'b0; DrawX = '0; DrawY = '0;
        hs_in = 1'b1; vs_in = 1'b1; blank_in = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0;
        set_prev_reset();
        repeat (3) @(negedge Clk);
        check("rst_mem_req", int'(mem_req), 0);
        check("rst_mem_addr", int'(mem_addr), 0);
        check("rst_rgb", int'(rgb), 0);
        check("rst_hs_out", int'(hs_out), 1);
        check("rst_vs_out", int'(vs_out), 1);
        check("rst_blank_out", int'(blank_out), 0);
        check("rst_underrun", int'(underrun), 0);
        Reset_n = 1'b1;

        for (int i = 0; i < 9; i++) apply_row(tbl[i]);

        // Slow memory: the fetch for line 2 cannot finish within line 1.
        lat = 8;
        apply_row('{1, -1, 1, -1, 0, 0, 0});
        apply_row('{2, -1, -1, -1, 0, 0, 1});
        check("restart_req_y2", int'(req0), 1);
        check("restart_addr_y2", int'(addr0), 1440);
        apply_row('{3, -1, -1, -1, 0, 0, 1});
        check("restart_addr_y3", int'(addr0), 1920);

        // Asynchronous reset in the middle of a fetch.
        check("req_before_rst", int'(mem_req), 1);
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        check("midrst_mem_req", int'(mem_req), 0);
        check("midrst_mem_addr", int'(mem_addr), 0);
        check("midrst_rgb", int'(rgb), 0);
        check("midrst_underrun", int'(underrun), 0);
        lat = 2;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        set_prev_reset();
        apply_row(tbl[7]);
        apply_row(tbl[8]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
